pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL expose parameter: PC_W, 64, width of every PC port.
REQ-002 SHALL have: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have: if_stall_req  input  1  fetch waiting on instruction bus.
REQ-005 SHALL have: id_stall_req  input  1  load-use hazard detected in decode.
REQ-006 SHALL have: mem_stall_req  input  1  data bus wait in mem stage.
REQ-007 SHALL have: id_flush  input  1, jalr_pc  input  PC_W  decode jalr redirect request and target.
REQ-008 SHALL have: ex_br_ena  input  1, ex_br_pc  input  PC_W  taken branch resolved in ex, and target.
REQ-009 SHALL have: trap_req  input  1, trap_pc  input  PC_W  ecall/mret in decode, and precomputed mtvec/mepc target.
REQ-010 SHALL have: ex_valid  input  1, mem_valid  input  1  ex/mem stages hold a live instruction.
REQ-011 SHALL have: stall_o  output  5  hold bits {mem_wb, ex_mem, id_ex, if_id, pc}, bit0 = pc.
REQ-012 SHALL have: flush_o  output  3  bubble bits {ex_mem, id_ex, if_id}, bit0 = if_id.
REQ-013 SHALL have: redirect_ena_o  output  1, redirect_pc_o  output  PC_W  pc load request and target.
REQ-014 SHALL have: trap_busy_o  output  1 (FSM not IDLE), trap_done_o  output  1 (one-cycle pulse).

Function
REQ-015 SHALL implement trap FSM states IDLE, DRAIN, REDIR.
REQ-016 IDLE->DRAIN SHALL occur when trap_req=1, mem_stall_req=0, ex_br_ena=0.
REQ-017 DRAIN SHALL drive stall_o[1:0]=2'b11, flush_o[1]=1 until ex_valid=0, mem_valid=0, mem_stall_req=0, then go REDIR.
REQ-018 DRAIN with ex_br_ena=1 SHALL abort to IDLE; the branch redirect wins that cycle.
REQ-019 REDIR SHALL last exactly one cycle: redirect_ena_o=1, redirect_pc_o=latched trap_pc, flush_o[0]=1, trap_done_o=1, then IDLE.
REQ-020 trap_pc SHALL be latched on the IDLE->DRAIN edge; later changes are ignored.
REQ-021 Priority per cycle SHALL be: mem_stall_req > ex_br_ena > trap FSM > id_stall_req > id_flush > if_stall_req.
REQ-022 mem_stall_req=1 SHALL give stall_o=5'b11111, flush_o=0, redirect_ena_o=0; FSM and pending state hold.
REQ-023 ex_br_ena SHALL give redirect_ena_o=1, redirect_pc_o=ex_br_pc, flush_o=3'b011, same cycle (combinational).
REQ-024 id_stall_req SHALL give stall_o=5'b00011, flush_o=3'b010 (bubble into ex).
REQ-025 id_flush SHALL give redirect_ena_o=1, redirect_pc_o=jalr_pc, flush_o=3'b001.
REQ-026 if_stall_req alone SHALL give stall_o=5'b00011, flush_o=3'b010.
REQ-027 A redirect with if_stall_req=1 SHALL set a pending register (valid+pc); redirect_ena_o stays 1 with that pc until the first cycle if_stall_req=0, then clears.
REQ-028 A newer higher-priority redirect SHALL overwrite the pending pc; a lower-priority one SHALL NOT.
REQ-029 id_stall_req together with id_flush SHALL stall only; jalr is not taken until id_stall_req drops.
REQ-030 With no request active, all outputs SHALL be 0.

Reset
REQ-031 rst=1 SHALL on the next edge set FSM=IDLE, clear pending valid/pc and the latched trap_pc.
REQ-032 While rst=1 all outputs SHALL be 0, independent of inputs.
REQ-033 Reset asserted in DRAIN or REDIR SHALL abort the trap with no trap_done_o pulse.

Verification
REQ-034 Load-use: id_stall_req=1 for 1 cycle -> stall_o=5'b00011, flush_o=3'b010 that cycle, all 0 next.
REQ-035 Trap: trap_req, trap_pc=0x80000100, ex_valid=1 for 2 cycles -> DRAIN 2 cycles, then REDIR with redirect_pc_o=0x80000100, trap_done_o pulse 1 cycle.
REQ-036 Abort: in DRAIN assert ex_br_ena, ex_br_pc=0x80000040 -> redirect to 0x80000040, flush_o=3'b011, FSM IDLE, no trap_done_o.
REQ-037 Pending: id_flush, jalr_pc=0x80000200 with if_stall_req=1 for 3 cycles -> redirect_ena_o held 4 cycles at 0x80000200, low after.
REQ-038 Mem stall: mem_stall_req=1 with ex_br_ena=1 -> stall_o=5'b11111, no redirect; mem_stall_req drops -> redirect to ex_br_pc.
REQ-039 Reset mid-DRAIN: rst=1 for 1 cycle -> all outputs 0, trap_busy_o=0, no trap_done_o.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline hazard / redirect controller for a 5-stage in-order core.
// Arbitrates stall, flush and PC-redirect requests in a fixed priority
// order, sequences ecall/mret traps through a drain-then-redirect FSM and
// parks a redirect while fetch is stalled so it is not lost.
//
// Handshake note: there is no valid/ready pair here. Every request input is
// a level that is honoured in the cycle it is high. redirect_ena_o is a level
// that the PC register samples on the next rising edge. A redirect raised
// while if_stall_req=1 stays asserted until the first cycle with
// if_stall_req=0; that is the cycle the fetch unit consumes it.
module pipe_ctrl #(
    parameter int unsigned PC_W = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_stall_req,
    input  logic            id_stall_req,
    input  logic            mem_stall_req,
    input  logic            id_flush,
    input  logic [PC_W-1:0] jalr_pc,
    input  logic            ex_br_ena,
    input  logic [PC_W-1:0] ex_br_pc,
    input  logic            trap_req,
    input  logic [PC_W-1:0] trap_pc,
    input  logic            ex_valid,
    input  logic            mem_valid,
    output logic [4:0]      stall_o,
    output logic [2:0]      flush_o,
    output logic            redirect_ena_o,
    output logic [PC_W-1:0] redirect_pc_o,
    output logic            trap_busy_o,
    output logic            trap_done_o,
    output logic [1:0]      dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_REDIR = 2'd2
    } state_t;

    // Redirect source rank, used to decide whether a new redirect may
    // replace one that is parked behind a fetch stall.
    localparam logic [1:0] P_NONE = 2'd0;
    localparam logic [1:0] P_JALR = 2'd1;
    localparam logic [1:0] P_TRAP = 2'd2;
    localparam logic [1:0] P_BR   = 2'd3;

    state_t          r_state;
    logic [PC_W-1:0] r_trap_pc;
    logic            r_pend_vld;
    logic [PC_W-1:0] r_pend_pc;
    logic [1:0]      r_pend_prio;

    state_t          w_state_nxt;
    logic            w_latch_trap;
    logic [4:0]      w_stall;
    logic [2:0]      w_flush;
    logic            w_new_ena;
    logic [PC_W-1:0] w_new_pc;
    logic [1:0]      w_new_prio;
    logic            w_done;
    logic            w_take_new;
    logic            w_redir_ena;
    logic [PC_W-1:0] w_redir_pc;

    // Fixed-priority arbitration of this cycle's requests and FSM next state.
    always_comb begin
        w_state_nxt  = r_state;
        w_latch_trap = 1'b0;
        w_stall      = 5'b00000;
        w_flush      = 3'b000;
        w_new_ena    = 1'b0;
        w_new_pc     = '0;
        w_new_prio   = P_NONE;
        w_done       = 1'b0;
        if (mem_stall_req) begin
            // Whole pipe frozen; FSM and parked redirect hold their state.
            w_stall = 5'b11111;
        end else if (ex_br_ena) begin
            // A resolved branch beats any in-flight trap (the trap was on
            // the wrong path).
            w_new_ena   = 1'b1;
            w_new_pc    = ex_br_pc;
            w_new_prio  = P_BR;
            w_flush     = 3'b011;
            w_state_nxt = S_IDLE;
        end else if (r_state == S_DRAIN) begin
            // Hold the trapping instruction in decode, bubble ex, and let
            // older instructions retire.
            w_stall = 5'b00011;
            w_flush = 3'b010;
            if (!ex_valid && !mem_valid) begin
                w_state_nxt = S_REDIR;
            end
        end else if (r_state == S_REDIR) begin
            w_new_ena   = 1'b1;
            w_new_pc    = r_trap_pc;
            w_new_prio  = P_TRAP;
            w_flush     = 3'b001;
            w_done      = 1'b1;
            w_state_nxt = S_IDLE;
        end else begin
            // Trap acceptance only arms the FSM; this cycle is otherwise
            // arbitrated among the decode/fetch requests.
            if (trap_req) begin
                w_state_nxt  = S_DRAIN;
                w_latch_trap = 1'b1;
            end
            if (id_stall_req) begin
                // Load-use stall also suppresses a jalr sitting in decode.
                w_stall = 5'b00011;
                w_flush = 3'b010;
            end else if (id_flush) begin
                w_new_ena  = 1'b1;
                w_new_pc   = jalr_pc;
                w_new_prio = P_JALR;
                w_flush    = 3'b001;
            end else if (if_stall_req) begin
                w_stall = 5'b00011;
                w_flush = 3'b010;
            end
        end
    end

    // Merge the fresh redirect with the parked one; an equal or higher rank
    // (newer) redirect wins, a lower rank one is dropped.
    always_comb begin
        w_take_new  = w_new_ena && (!r_pend_vld || (w_new_prio >= r_pend_prio));
        w_redir_ena = 1'b0;
        w_redir_pc  = '0;
        if (!mem_stall_req) begin
            if (w_take_new) begin
                w_redir_ena = 1'b1;
                w_redir_pc  = w_new_pc;
            end else if (r_pend_vld) begin
                w_redir_ena = 1'b1;
                w_redir_pc  = r_pend_pc;
            end
        end
    end

    // Trap FSM, latched trap target and parked-redirect register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_trap_pc   <= '0;
            r_pend_vld  <= 1'b0;
            r_pend_pc   <= '0;
            r_pend_prio <= P_NONE;
        end else begin
            r_state <= w_state_nxt;
            if (w_latch_trap) begin
                r_trap_pc <= trap_pc;
            end
            if (!mem_stall_req) begin
                if (if_stall_req) begin
                    if (w_take_new) begin
                        r_pend_vld  <= 1'b1;
                        r_pend_pc   <= w_new_pc;
                        r_pend_prio <= w_new_prio;
                    end
                end else begin
                    // Fetch is free this cycle, so the redirect on the bus
                    // is consumed now.
                    r_pend_vld  <= 1'b0;
                    r_pend_pc   <= '0;
                    r_pend_prio <= P_NONE;
                end
            end
        end
    end

    // Reset forces every control output low regardless of inputs.
    assign stall_o        = rst ? 5'b00000 : w_stall;
    assign flush_o        = rst ? 3'b000 : w_flush;
    assign redirect_ena_o = rst ? 1'b0 : w_redir_ena;
    assign redirect_pc_o  = rst ? '0 : w_redir_pc;
    assign trap_busy_o    = !rst && (r_state != S_IDLE);
    assign trap_done_o    = !rst && w_done;
    assign dbg_state_o    = r_state;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: the driver applies one input vector per
// cycle and queues the hand-computed outputs; the monitor pops and compares
// on the falling edge of the same cycle.
module tb_pipe_ctrl;

  localparam int PC_W = 64;
  localparam int EW   = 5 + 3 + 1 + PC_W + 1 + 1;

  localparam logic [PC_W-1:0] T_PC   = 64'h0000_0000_8000_0100;
  localparam logic [PC_W-1:0] T_PC2  = 64'h0000_0000_DEAD_BEE0;
  localparam logic [PC_W-1:0] ABT_PC = 64'h0000_0000_8000_0040;
  localparam logic [PC_W-1:0] J_PC   = 64'h0000_0000_8000_0300;
  localparam logic [PC_W-1:0] J2_PC  = 64'h0000_0000_8000_0200;
  localparam logic [PC_W-1:0] J3_PC  = 64'h0000_0000_8000_0400;
  localparam logic [PC_W-1:0] J4_PC  = 64'h0000_0000_8000_0500;
  localparam logic [PC_W-1:0] B1_PC  = 64'h0000_0000_8000_1000;
  localparam logic [PC_W-1:0] B2_PC  = 64'h0000_0000_8000_2000;
  localparam logic [PC_W-1:0] B3_PC  = 64'h0000_0000_8000_3000;
  localparam logic [PC_W-1:0] Z_PC   = 64'h0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic            if_stall_req, id_stall_req, mem_stall_req, id_flush;
  logic [PC_W-1:0] jalr_pc, ex_br_pc, trap_pc;
  logic            ex_br_ena, trap_req, ex_valid, mem_valid;
  logic [4:0]      stall_o;
  logic [2:0]      flush_o;
  logic            redirect_ena_o;
  logic [PC_W-1:0] redirect_pc_o;
  logic            trap_busy_o, trap_done_o;
  logic [1:0]      dbg_state_o;

  pipe_ctrl #(.PC_W(PC_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .if_stall_req   (if_stall_req),
    .id_stall_req   (id_stall_req),
    .mem_stall_req  (mem_stall_req),
    .id_flush       (id_flush),
    .jalr_pc        (jalr_pc),
    .ex_br_ena      (ex_br_ena),
    .ex_br_pc       (ex_br_pc),
    .trap_req       (trap_req),
    .trap_pc        (trap_pc),
    .ex_valid       (ex_valid),
    .mem_valid      (mem_valid),
    .stall_o        (stall_o),
    .flush_o        (flush_o),
    .redirect_ena_o (redirect_ena_o),
    .redirect_pc_o  (redirect_pc_o),
    .trap_busy_o    (trap_busy_o),
    .trap_done_o    (trap_done_o),
    .dbg_state_o    (dbg_state_o)
  );

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  string         nm_q[$];
  int            checks = 0;
  int            errors = 0;
  logic [EW-1:0] exp_v;
  logic [EW-1:0] got_v;
  string         exp_nm;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_v  = exp_q.pop_front();
      exp_nm = nm_q.pop_front();
      got_v  = {stall_o, flush_o, redirect_ena_o, redirect_pc_o, trap_busy_o, trap_done_o};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL %s: got stall=%b flush=%b ena=%b pc=%h busy=%b done=%b, exp stall=%b flush=%b ena=%b pc=%h busy=%b done=%b",
                 exp_nm, got_v[EW-1 -: 5], got_v[EW-6 -: 3], got_v[EW-9], got_v[PC_W+1:2], got_v[1], got_v[0],
                 exp_v[EW-1 -: 5], exp_v[EW-6 -: 3], exp_v[EW-9], exp_v[PC_W+1:2], exp_v[1], exp_v[0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clr();
    rst           = 1'b0;
    if_stall_req  = 1'b0;
    id_stall_req  = 1'b0;
    mem_stall_req = 1'b0;
    id_flush      = 1'b0;
    jalr_pc       = '0;
    ex_br_ena     = 1'b0;
    ex_br_pc      = '0;
    trap_req      = 1'b0;
    trap_pc       = '0;
    ex_valid      = 1'b0;
    mem_valid     = 1'b0;
  endtask

  // Queue the expected outputs for the vector currently driven, then
  // advance one clock.
  task automatic step(input string nm, input logic [4:0] es, input logic [2:0] ef,
                      input logic ee, input logic [PC_W-1:0] ep,
                      input logic eb, input logic ed);
    exp_q.push_back({es, ef, ee, ep, eb, ed});
    nm_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    clr();
    rst = 1'b1;
    @(posedge clk);
    #1;

    // reset gates outputs even with requests active
    clr(); rst = 1'b1; id_stall_req = 1'b1; ex_br_ena = 1'b1;
    ex_br_pc = {$urandom(), $urandom()};
    step("rst_gate", 5'b00000, 3'b000, 1'b0, Z_PC, 1'b0, 1'b0);
    clr();
    step("idle", 5'b00000, 3'b000, 1'b0, Z_PC, 1'b0, 1'b0);

    // load-use stall for one cycle
    clr(); id_stall_req = 1'b1;
    step("load_use", 5'b00011, 3'b010, 1'b0, Z_PC, 1'b0, 1'b0);
    clr();
    step("load_use_after", 5'b00000, 3'b000, 1'b0, Z_PC, 1'b0, 1'b0);

    // fetch stall alone
    clr(); if_stall_req = 1'b1;
    step("if_stall", 5'b00011, 3'b010, 1'b0, Z_PC, 1'b0, 1'b0);

    // load-use beats jalr, then jalr taken
    clr(); id_stall_req = 1'b1; id_flush = 1'b1; jalr_pc = J_PC;
    step("idstall_jalr", 5'b00011, 3'b010, 1'b0, Z_PC, 1'b0, 1'b0);
    clr(); id_flush = 1'b1; jalr_pc = J_PC;
    step("jalr", 5'b00000, 3'b001, 1'b1, J_PC, 1'b0, 1'b0);
    clr();
    step("jalr_after", 5'b00000, 3'b000, 1'b0, Z_PC, 1'b0, 1'b0);

    // plain branch
    clr(); ex_br_ena = 1'b1; ex_br_pc = B1_PC;
    step("branch", 5'b00000, 3'b011, 1'b1, B1_PC, 1'b0, 1'b0);

    // trap: accept, drain while ex/mem busy, redirect
    clr(); trap_req = 1'b1; trap_pc = T_PC; ex_valid = 1'b1;
    step("trap_accept", 5'b00000, 3'b000, 1'b0, Z_PC, 1'b0, 1'b0);
    clr(); trap_req = 1'b1; trap_pc = T_PC2; ex_valid = 1'b1;
    step("trap_drain1", 5'b00011, 3'b010, 1'b0, Z_PC, 1'b1, 1'b0);
    clr(); mem_valid = 1'b1;
    step("trap_drain2", 5'b00011, 3'b010, 1'b0, Z_PC, 1'b1, 1'b0);
    clr();
    step("trap_drain3", 5'b00011, 3'b010, 1'b0, Z_PC, 1'b1, 1'b0);
    clr();
    step("trap_redir", 5'b00000, 3'b001, 1'b1, T_PC, 1'b1, 1'b1);
    clr();
    step("trap_after", 5'b00000, 3'b000, 1'b0, Z_PC, 1'b0, 1'b0);

    // trap aborted by a branch in DRAIN
    clr(); trap_req = 1'b1; trap_pc = T_PC;
    step("abort_accept", 5'b00000, 3'b000, 1'b0, Z_PC, 1'b0, 1'b0);
    clr(); ex_valid = 1'b1;
    step("abort_drain", 5'b00011, 3'b010, 1'b0, Z_PC, 1'b1, 1'b0);
    clr(); ex_br_ena = 1'b1; ex_br_pc = ABT_PC; ex_valid = 1'b1;
    step("abort_branch", 5'b00000, 3'b011, 1'b1, ABT_PC, 1'b1, 1'b0);
    clr();
    step("abort_idle", 5'b00000, 3'b000, 1'b0, Z_PC, 1'b0, 1'b0);

    // jalr parked behind a 3-cycle fetch stall
    clr(); id_flush = 1'b1; jalr_pc = J2_PC; if_stall_req = 1'b1;
    step("pend_set", 5'b00000, 3'b001, 1'b1, J2_PC, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      clr(); if_stall_req = 1'b1;
      step("pend_hold", 5'b00011, 3'b010, 1'b1, J2_PC, 1'b0, 1'b0);
    end
    clr();
    step("pend_release", 5'b00000, 3'b000, 1'b1, J2_PC, 1'b0, 1'b0);
    clr();
    step("pend_cleared", 5'b00000, 3'b000, 1'b0, Z_PC, 1'b0, 1'b0);

    // parked jalr overwritten by branch; later jalr must not overwrite
    clr(); id_flush = 1'b1; jalr_pc = J3_PC; if_stall_req = 1'b1;
    step("ovr_jalr", 5'b00000, 3'b001, 1'b1, J3_PC, 1'b0, 1'b0);
    clr(); ex_br_ena = 1'b1; ex_br_pc = B2_PC; if_stall_req = 1'b1;
    step("ovr_branch", 5'b00000, 3'b011, 1'b1, B2_PC, 1'b0, 1'b0);
    clr(); id_flush = 1'b1; jalr_pc = J4_PC; if_stall_req = 1'b1;
    step("ovr_low_jalr", 5'b00000, 3'b001, 1'b1, B2_PC, 1'b0, 1'b0);
    clr();
    step("ovr_release", 5'b00000, 3'b000, 1'b1, B2_PC, 1'b0, 1'b0);
    clr();
    step("ovr_cleared", 5'b00000, 3'b000, 1'b0, Z_PC, 1'b0, 1'b0);

    // mem stall blocks a branch, branch proceeds once it drops
    clr(); mem_stall_req = 1'b1; ex_br_ena = 1'b1; ex_br_pc = B3_PC;
    step("mem_stall_br", 5'b11111, 3'b000, 1'b0, Z_PC, 1'b0, 1'b0);
    clr(); ex_br_ena = 1'b1; ex_br_pc = B3_PC;
    step("mem_release_br", 5'b00000, 3'b011, 1'b1, B3_PC, 1'b0, 1'b0);
    clr();
    step("mem_after", 5'b00000, 3'b000, 1'b0, Z_PC, 1'b0, 1'b0);

    // reset in DRAIN: no redirect, no done pulse afterwards
    clr(); trap_req = 1'b1; trap_pc = T_PC;
    step("rstd_accept", 5'b00000, 3'b000, 1'b0, Z_PC, 1'b0, 1'b0);
    clr(); mem_stall_req = 1'b1;
    step("rstd_memhold", 5'b11111, 3'b000, 1'b0, Z_PC, 1'b1, 1'b0);
    clr(); rst = 1'b1;
    step("rstd_reset", 5'b00000, 3'b000, 1'b0, Z_PC, 1'b0, 1'b0);
    clr();
    step("rstd_no_done", 5'b00000, 3'b000, 1'b0, Z_PC, 1'b0, 1'b0);
    clr();
    step("rstd_idle", 5'b00000, 3'b000, 1'b0, Z_PC, 1'b0, 1'b0);

    // ---------------- report ----------------
    repeat (2) @(posedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries never compared, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
